// File: rtl/display_scan_mux_pkg.sv
// Shared types and constants for the multiplexed 7-segment display scanner.
package display_scan_mux_pkg;

    localparam int unsigned NIBBLE_W   = 4;
    localparam int unsigned MAX_DIGITS = 32;

    // All anodes inactive (active-low); truncated to the digit count by users.
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_t;

endpackage

// File: rtl/display_scan_mux_scan_prescaler.sv
// Slot counter for the display scanner: counts cycles within one digit slot
// and flags the end of the blanking gap and the end of the slot.
module scan_prescaler #(
    parameter int unsigned  REFRESH_DIV  = 100000,
    parameter int unsigned  BLANK_CYCLES = 1000,
    localparam int unsigned CNT_W        = $clog2(REFRESH_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic blank_end_c,
    output logic slot_end_c
);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Slot counter: held at zero while cleared, wraps at the end of each slot
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            cnt_q <= '0;
        end else if (cnt_q == SLOT_LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign blank_end_c = (cnt_q == BLANK_LAST);
    assign slot_end_c  = (cnt_q == SLOT_LAST);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed hex display scanner with per-frame digit snapshot and an
// all-dark blanking gap at the start of every digit slot.
// Optional: define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module display_scan_mux
    import display_scan_mux_pkg::*;
#(
    parameter int unsigned  NUM_DIGITS   = 4,
    parameter int unsigned  REFRESH_DIV  = 100000,
    parameter int unsigned  BLANK_CYCLES = 1000,
    localparam int unsigned CNT_W        = $clog2(REFRESH_DIV),
    localparam int unsigned IDX_W        = $clog2(NUM_DIGITS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]        dp_in,
    output logic [NIBBLE_W-1:0]          digit_out,
    output logic                         dp_n,
    output logic [NUM_DIGITS-1:0]        anode_n,
    output logic [IDX_W-1:0]             scan_idx,
    output logic                         frame_done
);

    localparam logic [NUM_DIGITS-1:0] ANODE_ALL_OFF = NUM_DIGITS'(ANODE_OFF);
    localparam logic [IDX_W-1:0]      LAST_IDX      = IDX_W'(NUM_DIGITS - 1);

    scan_state_t                    state_q, state_d;
    logic [IDX_W-1:0]               idx_d;
    logic [NIBBLE_W*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]          dp_snap_q, dp_snap_d;
    logic [NUM_DIGITS-1:0]          mask_q, mask_d;
    logic [NUM_DIGITS-1:0]          mask_c;
    logic                           frame_done_d;
    nibble_t                        digit_d;
    logic                           dp_n_d;
    logic [NUM_DIGITS-1:0]          anode_d;
    logic                           lit_c;
    logic                           pre_clear_c;
    logic                           blank_end_c;
    logic                           slot_end_c;

`ifdef LEADING_ZERO_BLANK_EN
    // Leading-zero mask: a digit is dark while it and all digits above it are
    // zero; a decimal point request stops blanking from that digit downward.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [NIBBLE_W*NUM_DIGITS-1:0] d,
        input logic [NUM_DIGITS-1:0]          dp
    );
        logic run;
        run     = 1'b1;
        lz_mask = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if ((d[NIBBLE_W*i +: NIBBLE_W] != nibble_t'(0)) || dp[i]) begin
                run = 1'b0;
            end
            lz_mask[i] = run;
        end
    endfunction

    assign mask_c = lz_mask(digits_in, dp_in);
`else
    assign mask_c = '0;
`endif

    // Slot counter runs only while scanning and enabled
    assign pre_clear_c = (state_q == IDLE) || !en;

    scan_prescaler #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (pre_clear_c),
        .blank_end_c (blank_end_c),
        .slot_end_c  (slot_end_c)
    );

    // Next state, index, snapshot and the registered outputs they imply
    always_comb begin
        state_d      = state_q;
        idx_d        = scan_idx;
        snap_d       = snap_q;
        dp_snap_d    = dp_snap_q;
        mask_d       = mask_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = BLANK;
                    idx_d     = '0;
                    snap_d    = digits_in;
                    dp_snap_d = dp_in;
                    mask_d    = mask_c;
                end
            end
            BLANK: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (blank_end_c) begin
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (!en) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (slot_end_c) begin
                    state_d = BLANK;
                    if (scan_idx == LAST_IDX) begin
                        idx_d        = '0;
                        snap_d       = digits_in;
                        dp_snap_d    = dp_in;
                        mask_d       = mask_c;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = scan_idx + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        digit_d = snap_d[{idx_d, 2'b00} +: NIBBLE_W];
        lit_c   = (state_d == SHOW) && !mask_d[idx_d];
        anode_d = lit_c ? (ANODE_ALL_OFF & ~(NUM_DIGITS'(1) << idx_d)) : ANODE_ALL_OFF;
        dp_n_d  = lit_c ? ~dp_snap_d[idx_d] : 1'b1;
    end

    // State, snapshot and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            scan_idx   <= '0;
            snap_q     <= '0;
            dp_snap_q  <= '0;
            mask_q     <= '0;
            digit_out  <= '0;
            dp_n       <= 1'b1;
            anode_n    <= ANODE_ALL_OFF;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            scan_idx   <= idx_d;
            snap_q     <= snap_d;
            dp_snap_q  <= dp_snap_d;
            mask_q     <= mask_d;
            digit_out  <= digit_d;
            dp_n       <= dp_n_d;
            anode_n    <= anode_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// Self-checking bench for display_scan_mux (4 digits, 8-cycle slots, 2-cycle gap).
module tb_display_scan_mux;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  digit_out;
    logic        dp_n;
    logic [3:0]  anode_n;
    logic [1:0]  scan_idx;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // Reference timing model: cycles since scan start, snapshot, lit digits
    int          m_k    = 0;
    logic [15:0] m_snap = '0;
    logic [3:0]  m_dp   = '0;
    logic [3:0]  m_lit  = 4'hF;

    display_scan_mux #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .digit_out  (digit_out),
        .dp_n       (dp_n),
        .anode_n    (anode_n),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s k=%0d got=%h exp=%h", tag, m_k, got, exp);
        end
    endtask

    // Take one clock edge (inputs sampled as they are now), then check outputs
    task automatic tick_check();
        logic        r, e;
        logic [15:0] d;
        logic [3:0]  p;
        int          pos, dig;
        logic        fd, show;
        logic [3:0]  exp_an;
        logic        exp_dpn;
        r = rst_n;
        e = en;
        d = digits_in;
        p = dp_in;
        @(negedge clk);
        if (!r) begin
            m_k    = 0;
            m_snap = '0;
            m_dp   = '0;
            check("rst_anode", 32'(anode_n), 32'hF);
            check("rst_dpn", 32'(dp_n), 32'h1);
            check("rst_digit", 32'(digit_out), 32'h0);
            check("rst_idx", 32'(scan_idx), 32'h0);
            check("rst_fd", 32'(frame_done), 32'h0);
        end else if (!e) begin
            m_k = 0;
            check("idle_anode", 32'(anode_n), 32'hF);
            check("idle_dpn", 32'(dp_n), 32'h1);
            check("idle_idx", 32'(scan_idx), 32'h0);
            check("idle_fd", 32'(frame_done), 32'h0);
        end else begin
            m_k++;
            pos = (m_k - 1) % 8;
            dig = ((m_k - 1) / 8) % 4;
            fd  = (m_k > 1) && (((m_k - 1) % 32) == 0);
            if (m_k == 1 || fd) begin
                m_snap = d;
                m_dp   = p;
            end
            show    = (pos >= 2) && m_lit[dig];
            exp_an  = show ? ~(4'b0001 << dig) : 4'hF;
            exp_dpn = show ? ~m_dp[dig] : 1'b1;
            check("scan_anode", 32'(anode_n), 32'(exp_an));
            check("scan_dpn", 32'(dp_n), 32'(exp_dpn));
            check("scan_digit", 32'(digit_out), 32'(m_snap[dig*4 +: 4]));
            check("scan_idx", 32'(scan_idx), 32'(dig));
            check("scan_fd", 32'(frame_done), 32'(fd));
        end
    endtask

    // Reset for a few cycles, then release with the given display contents
    task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic [3:0] lit, input int cycles);
        rst_n     = 1'b0;
        digits_in = d;
        dp_in     = p;
        m_lit     = lit;
        repeat (2) tick_check();
        rst_n = 1'b1;
        repeat (cycles) tick_check();
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        digits_in = 16'h1A3F;
        dp_in     = 4'b0100;

        // Reset held three cycles with en high
        repeat (3) tick_check();
        rst_n = 1'b1;

        // Two full frames plus wrap; digits change mid-frame during digit 1 SHOW
        for (int i = 0; i < 65; i++) begin
            tick_check();
            if (m_k == 12) digits_in = 16'h2222;
        end

        // Advance to digit 2 SHOW, then drop enable
        repeat (18) tick_check();
        check("at_digit2_show_idx", 32'(scan_idx), 32'h2);
        en = 1'b0;
        tick_check();

        // Re-enable with new contents: fresh snapshot, restart at digit 0
        en        = 1'b1;
        digits_in = 16'h0BC7;
        dp_in     = 4'b0000;
        repeat (27) tick_check();

        // Reset during digit 3 SHOW
        check("at_digit3_show_idx", 32'(scan_idx), 32'h3);
        rst_n = 1'b0;
        tick_check();
        rst_n = 1'b1;
        repeat (10) tick_check();

`ifdef LEADING_ZERO_BLANK_EN
        restart(16'h0050, 4'b0000, 4'b0011, 33);
        restart(16'h0000, 4'b0000, 4'b0001, 33);
        restart(16'h0000, 4'b0100, 4'b0111, 33);
`else
        restart(16'h0050, 4'b0000, 4'b1111, 33);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
